// File: rtl/sense_conditioner.sv
// sense_conditioner: per-channel synchronizer + debounce FSM turning entry/exit photocells into clean pulses.
// Define STUCK_DETECT_EN to add per-channel stuck-beam detection on StuckFlag.
module sense_conditioner #(
  parameter int DEB_CYCLES   = 8,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic RawIn,
  input  logic RawOut,
  output logic SenseIn,
  output logic SenseOut,
  output logic StuckFlag
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, QUAL_H, HIGH, QUAL_L} state_t;

  if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_bad_deb
    $error("DEB_CYCLES out of range 2..255");
  end
  if (STUCK_CYCLES < 2 || STUCK_CYCLES > 65535) begin : g_bad_stuck
    $error("STUCK_CYCLES out of range 2..65535");
  end

  logic [1:0] raw_w;
  logic [1:0] pulse_w;
`ifdef STUCK_DETECT_EN
  logic [1:0] stuck_w;
`endif

  assign raw_w = {RawOut, RawIn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic          sync1_q, sync2_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          pulse_q, pulse_d;

    always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= raw_w[gi];
        sync2_q <= sync1_q;
      end
    end

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // The pulse is issued only on the QUAL_H -> HIGH edge; release never pulses.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_d = QUAL_H;
            cnt_d   = CW'(1);
          end
        end
        QUAL_H: begin
          if (!sync2_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc >= DEB_LAST) begin
            state_d = HIGH;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HIGH: begin
          if (!sync2_q) begin
            state_d = QUAL_L;
            cnt_d   = CW'(1);
          end
        end
        QUAL_L: begin
          if (sync2_q) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_inc >= DEB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end

    assign pulse_w[gi] = pulse_q;

`ifdef STUCK_DETECT_EN
    localparam logic [15:0] STUCK_LIMIT = 16'(STUCK_CYCLES);
    logic [15:0] stk_cnt_q, stk_cnt_d;
    logic        stuck_q, stuck_d;

    // Count while the channel will be blocked after this edge; leaving for IDLE clears everything.
    always_comb begin
      stk_cnt_d = '0;
      stuck_d   = 1'b0;
      if (state_d == HIGH || state_d == QUAL_L) begin
        stk_cnt_d = (stk_cnt_q == 16'hFFFF) ? stk_cnt_q : stk_cnt_q + 16'd1;
        stuck_d   = stuck_q | (stk_cnt_d >= STUCK_LIMIT);
      end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
        stk_cnt_q <= '0;
        stuck_q   <= 1'b0;
      end else begin
        stk_cnt_q <= stk_cnt_d;
        stuck_q   <= stuck_d;
      end
    end

    assign stuck_w[gi] = stuck_d;
`endif
  end

  assign SenseIn  = pulse_w[0];
  assign SenseOut = pulse_w[1];

`ifdef STUCK_DETECT_EN
  logic stuck_flag_q;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) stuck_flag_q <= 1'b0;
    else         stuck_flag_q <= |stuck_w;
  end

  assign StuckFlag = stuck_flag_q;
`else
  assign StuckFlag = 1'b0;
`endif

endmodule
